// File: rtl/bank_cmd_scheduler_if.sv
// Request and command bundle shared by the requesters, the bank command
// scheduler and the downstream per-bank timing FSM.
interface bank_cmd_scheduler_if #(
   parameter int NREQ = 4,
   parameter int ROWW = 16
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_we;
   logic [NREQ*ROWW-1:0] req_row;
   logic [NREQ-1:0]      req_ready;
   logic                 cmd_act;
   logic                 cmd_rd;
   logic                 cmd_wr;
   logic                 cmd_pr;
   logic                 cmd_ref;
   logic [ROWW-1:0]      cmd_row;
   logic                 done_valid;
   logic [IDW-1:0]       done_id;
   logic                 row_open;
   logic                 busy;

   // Requester side: raises requests, observes grants and bank commands.
   modport master (
      output req_valid, req_we, req_row,
      input  req_ready, cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref, cmd_row,
             done_valid, done_id, row_open, busy
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_we, req_row,
      output req_ready, cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref, cmd_row,
             done_valid, done_id, row_open, busy
   );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// Single-bank command scheduler: round-robin arbitration over NREQ requesters,
// open-page policy with one tracked row, timed ACT/RD/WR/PR/REF pulses and
// periodic refresh insertion.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bank precharged; issue REF, a deferred ACT, or grant + ACT
// S_ACT_WAIT | ACT issued, waiting TRCD before the row may be accessed
// S_OPEN     | row open; issue latched RD/WR, PR for refresh, or grant
// S_PRE_WAIT | PR issued, waiting TRP before returning to IDLE
// S_REF_WAIT | REF issued, waiting TRFC before returning to IDLE
// S_CAS_WAIT | RD/WR issued, waiting TCL; completion pulse on exit
module bank_cmd_scheduler #(
   parameter int NREQ  = 4,
   parameter int ROWW  = 16,
   parameter int TRCD  = 22,
   parameter int TRP   = 20,
   parameter int TCL   = 14,
   parameter int TRFC  = 243,
   parameter int TREFI = 7800
) (
   input  logic                clk,
   input  logic                rst,
   bank_cmd_scheduler_if.slave bus
);
   localparam int IDW    = $clog2(NREQ);
   localparam int TMAX_A = (TRCD > TRP) ? TRCD : TRP;
   localparam int TMAX_B = (TCL > TRFC) ? TCL : TRFC;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int WAITW  = $clog2(TMAX);
   localparam int REFW   = $clog2(TREFI);

   localparam logic [WAITW-1:0] LD_TRCD  = WAITW'(TRCD - 1);
   localparam logic [WAITW-1:0] LD_TRP   = WAITW'(TRP - 1);
   localparam logic [WAITW-1:0] LD_TCL   = WAITW'(TCL - 1);
   localparam logic [WAITW-1:0] LD_TRFC  = WAITW'(TRFC - 1);
   localparam logic [REFW-1:0]  LD_TREFI = REFW'(TREFI - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACT_WAIT, S_OPEN, S_PRE_WAIT, S_REF_WAIT, S_CAS_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [WAITW-1:0] wait_q, wait_d;
   logic [REFW-1:0]  ref_cnt_q, ref_cnt_d;
   logic             ref_pend_q, ref_pend_d;
   logic             txn_q, txn_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             we_q, we_d;
   logic [ROWW-1:0]  row_q, row_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic             row_open_q, row_open_d;
   logic [ROWW-1:0]  open_row_q, open_row_d;
   logic             done_q, done_d;
   logic [IDW-1:0]   done_id_q, done_id_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [ROWW-1:0]  gnt_row;
   logic             gnt_we;
   logic             ref_clr;
   logic             wait_exit;

   logic [NREQ-1:0]  ready_c;
   logic             act_c, rd_c, wr_c, pr_c, ref_c;
   logic [ROWW-1:0]  row_c;

   assign wait_exit = (wait_q == WAITW'(1));

   // Round-robin pick: first valid requester at or after rr_q.
   always_comb begin
      int cand;
      cand      = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_row   = '0;
      gnt_we    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!gnt_found && bus.req_valid[IDW'(cand)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(cand);
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (IDW'(k) == gnt_idx) begin
            gnt_row = bus.req_row[k*ROWW +: ROWW];
            gnt_we  = bus.req_we[k];
         end
      end
   end

   // Refresh interval timer; a new expiry wins over a same-cycle REF clear.
   always_comb begin
      ref_cnt_d  = ref_cnt_q - 1'b1;
      ref_pend_d = ref_pend_q;
      if (ref_clr) ref_pend_d = 1'b0;
      if (ref_cnt_q == '0) begin
         ref_cnt_d  = LD_TREFI;
         ref_pend_d = 1'b1;
      end
   end

   // Next-state and command decode.
   always_comb begin
      state_d    = state_q;
      wait_d     = (wait_q != '0) ? wait_q - 1'b1 : '0;
      txn_d      = txn_q;
      id_d       = id_q;
      we_d       = we_q;
      row_d      = row_q;
      rr_d       = rr_q;
      row_open_d = row_open_q;
      open_row_d = open_row_q;
      done_d     = 1'b0;
      done_id_d  = '0;
      ref_clr    = 1'b0;
      ready_c    = '0;
      act_c      = 1'b0;
      rd_c       = 1'b0;
      wr_c       = 1'b0;
      pr_c       = 1'b0;
      ref_c      = 1'b0;
      row_c      = '0;

      case (state_q)
         S_IDLE: begin
            if (ref_pend_q) begin
               ref_c   = 1'b1;
               ref_clr = 1'b1;
               wait_d  = LD_TRFC;
               state_d = S_REF_WAIT;
            end else if (txn_q) begin
               act_c   = 1'b1;
               row_c   = row_q;
               wait_d  = LD_TRCD;
               state_d = S_ACT_WAIT;
            end else if (gnt_found) begin
               for (int k = 0; k < NREQ; k++)
                  if (IDW'(k) == gnt_idx) ready_c[k] = 1'b1;
               id_d    = gnt_idx;
               we_d    = gnt_we;
               row_d   = gnt_row;
               rr_d    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
               txn_d   = 1'b1;
               act_c   = 1'b1;
               row_c   = gnt_row;
               wait_d  = LD_TRCD;
               state_d = S_ACT_WAIT;
            end
         end
         S_ACT_WAIT: begin
            if (wait_exit) begin
               row_open_d = 1'b1;
               open_row_d = row_q;
               state_d    = S_OPEN;
            end
         end
         S_OPEN: begin
            if (txn_q) begin
               rd_c    = ~we_q;
               wr_c    = we_q;
               wait_d  = LD_TCL;
               state_d = S_CAS_WAIT;
            end else if (ref_pend_q) begin
               pr_c       = 1'b1;
               row_open_d = 1'b0;
               wait_d     = LD_TRP;
               state_d    = S_PRE_WAIT;
            end else if (gnt_found) begin
               for (int k = 0; k < NREQ; k++)
                  if (IDW'(k) == gnt_idx) ready_c[k] = 1'b1;
               id_d  = gnt_idx;
               we_d  = gnt_we;
               row_d = gnt_row;
               rr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
               txn_d = 1'b1;
               if (gnt_row == open_row_q) begin
                  rd_c    = ~gnt_we;
                  wr_c    = gnt_we;
                  wait_d  = LD_TCL;
                  state_d = S_CAS_WAIT;
               end else begin
                  // Miss: close the row now, the ACT is issued from IDLE.
                  pr_c       = 1'b1;
                  row_open_d = 1'b0;
                  wait_d     = LD_TRP;
                  state_d    = S_PRE_WAIT;
               end
            end
         end
         S_PRE_WAIT, S_REF_WAIT: begin
            if (wait_exit) state_d = S_IDLE;
         end
         S_CAS_WAIT: begin
            if (wait_exit) begin
               done_d    = 1'b1;
               done_id_d = id_q;
               txn_d     = 1'b0;
               state_d   = S_OPEN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         ref_cnt_q  <= LD_TREFI;
         ref_pend_q <= 1'b0;
         txn_q      <= 1'b0;
         id_q       <= '0;
         we_q       <= 1'b0;
         row_q      <= '0;
         rr_q       <= '0;
         row_open_q <= 1'b0;
         open_row_q <= '0;
         done_q     <= 1'b0;
         done_id_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         ref_cnt_q  <= ref_cnt_d;
         ref_pend_q <= ref_pend_d;
         txn_q      <= txn_d;
         id_q       <= id_d;
         we_q       <= we_d;
         row_q      <= row_d;
         rr_q       <= rr_d;
         row_open_q <= row_open_d;
         open_row_q <= open_row_d;
         done_q     <= done_d;
         done_id_q  <= done_id_d;
      end
   end

   // Command pulses are decoded from state; hold them quiet while in reset.
   assign bus.req_ready  = rst ? '0 : ready_c;
   assign bus.cmd_act    = act_c & ~rst;
   assign bus.cmd_rd     = rd_c & ~rst;
   assign bus.cmd_wr     = wr_c & ~rst;
   assign bus.cmd_pr     = pr_c & ~rst;
   assign bus.cmd_ref    = ref_c & ~rst;
   assign bus.cmd_row    = rst ? '0 : row_c;
   assign bus.done_valid = done_q;
   assign bus.done_id    = done_id_q;
   assign bus.row_open   = row_open_q;
   assign bus.busy       = (state_q != S_IDLE) | txn_q;
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Bench for bank_cmd_scheduler. The reference is a procedural timeline model:
// it walks through bank phases with explicit cycle waits and predicts every
// output for every cycle.
module tb_bank_cmd_scheduler;
   localparam int NREQ  = 4;
   localparam int ROWW  = 16;
   localparam int TRCD  = 22;
   localparam int TRP   = 20;
   localparam int TCL   = 14;
   localparam int TRFC  = 10;
   localparam int TREFI = 100;
   localparam int NDIR  = 6;

   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_ACT  = 5'b10000;
   localparam logic [4:0] C_RD   = 5'b01000;
   localparam logic [4:0] C_WR   = 5'b00100;
   localparam logic [4:0] C_PR   = 5'b00010;
   localparam logic [4:0] C_REF  = 5'b00001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bank_cmd_scheduler_if #(.NREQ(NREQ), .ROWW(ROWW)) bus ();

   bank_cmd_scheduler #(
      .NREQ(NREQ), .ROWW(ROWW), .TRCD(TRCD), .TRP(TRP),
      .TCL(TCL), .TRFC(TRFC), .TREFI(TREFI)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Requester state held by the bench.
   bit              rq_v[NREQ];
   bit              rq_we[NREQ];
   logic [ROWW-1:0] rq_row[NREQ];

   // Directed arrivals keyed by model cycle.
   int dir_cyc[NDIR] = '{40, 60, 130, 130, 130, 130};
   int dir_id[NDIR]  = '{2, 1, 0, 1, 2, 3};
   int dir_we[NDIR]  = '{1, 0, 0, 1, 0, 1};
   int dir_row[NDIR] = '{5, 9, 5, 5, 5, 5};
   bit dir_en;
   int rand_start;

   // Model state.
   bit              m_pend, m_open, m_txn, m_we, m_done, stop;
   int              m_cyc, m_rr, m_id, m_done_id, budget;
   logic [ROWW-1:0] m_row, m_open_row;

   task automatic drive_reqs();
      logic [NREQ-1:0]      v, we;
      logic [NREQ*ROWW-1:0] rw;
      v = '0; we = '0; rw = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (rq_v[k])  v  = v  | (NREQ'(1) << k);
         if (rq_we[k]) we = we | (NREQ'(1) << k);
         rw = rw | ((NREQ*ROWW)'(rq_row[k]) << (k*ROWW));
      end
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_row   = rw;
   endtask

   task automatic new_req(input int k, input bit we, input logic [ROWW-1:0] row);
      rq_v[k]   = 1'b1;
      rq_we[k]  = we;
      rq_row[k] = row;
   endtask

   function automatic logic [ROWW-1:0] pick_row();
      case ($urandom_range(0, 3))
         0, 1:    return 16'd5;
         2:       return 16'd9;
         default: return 16'($urandom_range(0, 15));
      endcase
   endfunction

   // One clock of the timeline: compare this cycle, then advance stimulus.
   task automatic tick(input logic [NREQ-1:0] e_ready, input logic [4:0] e_cmd,
                       input logic [ROWW-1:0] e_row, input bit e_busy);
      if (stop) return;
      @(negedge clk);
      check_val("req_ready", 32'(bus.req_ready), 32'(e_ready));
      check_val("cmd", 32'({bus.cmd_act, bus.cmd_rd, bus.cmd_wr, bus.cmd_pr, bus.cmd_ref}),
                32'(e_cmd));
      check_val("cmd_row", 32'(bus.cmd_row), 32'(e_row));
      check_val("done_valid", 32'(bus.done_valid), 32'(m_done));
      if (m_done) check_val("done_id", 32'(bus.done_id), 32'(m_done_id));
      check_val("row_open", 32'(bus.row_open), 32'(m_open));
      check_val("busy", 32'(bus.busy), 32'(e_busy));
      m_done = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++)
         if (((e_ready >> k) & NREQ'(1)) != '0) rq_v[k] = 1'b0;
      m_cyc++;
      if (m_cyc % TREFI == 0) m_pend = 1'b1;
      if (dir_en)
         for (int j = 0; j < NDIR; j++)
            if (dir_cyc[j] == m_cyc && !rq_v[dir_id[j]])
               new_req(dir_id[j], dir_we[j] != 0, 16'(dir_row[j]));
      if (m_cyc >= rand_start)
         for (int k = 0; k < NREQ; k++)
            if (!rq_v[k] && $urandom_range(0, 15) == 0)
               new_req(k, 1'($urandom_range(0, 1)), pick_row());
      drive_reqs();
      budget--;
      if (budget <= 0) stop = 1'b1;
   endtask

   // Quiet cycles after a command so the next decision lands T cycles later.
   task automatic waitn(input int t);
      for (int i = 1; i < t; i++) tick('0, C_NONE, '0, 1'b1);
   endtask

   function automatic int arb();
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_rr + k) % NREQ;
         if (rq_v[i]) return i;
      end
      return -1;
   endfunction

   task automatic grant(input int w);
      m_id  = w;
      m_we  = rq_we[w];
      m_row = rq_row[w];
      m_rr  = (w + 1) % NREQ;
   endtask

   task automatic open_phase();
      int w;
      m_open     = 1'b1;
      m_open_row = m_row;
      while (!stop) begin
         if (m_txn) begin
            tick('0, m_we ? C_WR : C_RD, '0, 1'b1);
            waitn(TCL);
            m_done = 1'b1; m_done_id = m_id; m_txn = 1'b0;
         end else if (m_pend) begin
            tick('0, C_PR, '0, 1'b1);
            m_open = 1'b0;
            waitn(TRP);
            return;
         end else begin
            w = arb();
            if (w < 0) tick('0, C_NONE, '0, 1'b1);
            else begin
               grant(w);
               if (m_row == m_open_row) begin
                  tick(NREQ'(1) << w, m_we ? C_WR : C_RD, '0, 1'b1);
                  waitn(TCL);
                  m_done = 1'b1; m_done_id = m_id;
               end else begin
                  tick(NREQ'(1) << w, C_PR, '0, 1'b1);
                  m_open = 1'b0; m_txn = 1'b1;
                  waitn(TRP);
                  return;
               end
            end
         end
      end
   endtask

   task automatic run_model(input int n);
      int w;
      m_pend = 0; m_open = 0; m_txn = 0; m_we = 0; m_done = 0; stop = 0;
      m_cyc = 0; m_rr = 0; m_id = 0; m_done_id = 0; budget = n;
      m_row = '0; m_open_row = '0;
      while (!stop) begin
         if (m_pend) begin
            m_pend = 1'b0;
            tick('0, C_REF, '0, m_txn);
            waitn(TRFC);
         end else if (m_txn) begin
            tick('0, C_ACT, m_row, 1'b1);
            waitn(TRCD);
            if (!stop) open_phase();
         end else begin
            w = arb();
            if (w < 0) tick('0, C_NONE, '0, 1'b0);
            else begin
               grant(w);
               tick(NREQ'(1) << w, C_ACT, m_row, 1'b0);
               m_txn = 1'b1;
               waitn(TRCD);
               if (!stop) open_phase();
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         rq_v[k] = 1'b0; rq_we[k] = 1'b0; rq_row[k] = '0;
      end
      drive_reqs();
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("reset_outputs",
                32'({bus.req_ready, bus.cmd_act, bus.cmd_rd, bus.cmd_wr, bus.cmd_pr,
                     bus.cmd_ref, bus.cmd_row, bus.done_valid, bus.done_id,
                     bus.row_open, bus.busy}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         rq_v[k] = 1'b0; rq_we[k] = 1'b0; rq_row[k] = '0;
      end
      drive_reqs();
      dir_en     = 1'b0;
      rand_start = 1 << 30;
      @(posedge clk);
      #1;
      do_reset();

      // Directed read, hit, miss, round robin and refresh, then random traffic.
      dir_en     = 1'b1;
      rand_start = 400;
      new_req(0, 1'b0, 16'd5);
      drive_reqs();
      run_model(3400);

      // Reset five cycles into an ACT wait; the next access must start with ACT.
      do_reset();
      dir_en     = 1'b0;
      rand_start = 1 << 30;
      new_req(0, 1'b0, 16'd5);
      drive_reqs();
      run_model(5);
      do_reset();
      new_req(0, 1'b0, 16'd5);
      drive_reqs();
      run_model(60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
